// File: rtl/decode_imm_ctrl_pkg.sv
// Shared ISA definitions for the decode/immediate stage: opcodes, FSM
// state encodings, immediate formats and the opcode-to-format decoder.
package decode_imm_ctrl_pkg;

  localparam logic [4:0] OP_HALT  = 5'b00000;
  localparam logic [4:0] OP_J     = 5'b00100;
  localparam logic [4:0] OP_JR    = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b00110;
  localparam logic [4:0] OP_JALR  = 5'b00111;
  localparam logic [4:0] OP_ADDI  = 5'b01000;
  localparam logic [4:0] OP_SUBI  = 5'b01001;
  localparam logic [4:0] OP_XORI  = 5'b01010;
  localparam logic [4:0] OP_ANDNI = 5'b01011;
  localparam logic [4:0] OP_BRNCH = 5'b011??;  // BEQZ/BNEZ/BLTZ/BGEZ
  localparam logic [4:0] OP_ST    = 5'b10000;
  localparam logic [4:0] OP_LD    = 5'b10001;
  localparam logic [4:0] OP_SLBI  = 5'b10010;
  localparam logic [4:0] OP_STU   = 5'b10011;
  localparam logic [4:0] OP_SHIFT = 5'b101??;  // ROLI/SLLI/RORI/SRLI
  localparam logic [4:0] OP_LBI   = 5'b11000;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  typedef enum logic [2:0] {NONE, I5S, I5Z, I8S, I8Z, J11} imm_fmt_e;

  // Map an opcode to the immediate format it carries
  function automatic imm_fmt_e imm_fmt(input logic [4:0] op);
    imm_fmt_e fmt;
    fmt = NONE;
    casez (op)
      OP_ADDI, OP_SUBI, OP_ST, OP_LD, OP_STU: fmt = I5S;
      OP_XORI, OP_ANDNI, OP_SHIFT:             fmt = I5Z;
      OP_BRNCH, OP_LBI, OP_JR, OP_JALR:        fmt = I8S;
      OP_SLBI:                                 fmt = I8Z;
      OP_J, OP_JAL:                            fmt = J11;
      default:                                 fmt = NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/decode_imm_ctrl_extender_block.sv
// Immediate extender: widens a 5- or 8-bit field to 16 bits, either
// sign- or zero-extended.
module extender_block (
  input  logic [7:0]  field,
  input  logic        imm_len,
  input  logic        imm_sign,
  output logic [15:0] imm
);

  // Pick the field width, then replicate the top bit only when signed
  always_comb begin
    if (imm_len) begin
      imm = {{11{imm_sign & field[4]}}, field[4:0]};
    end else begin
      imm = {{8{imm_sign & field[7]}}, field[7:0]};
    end
  end

endmodule

// File: rtl/decode_imm_ctrl.sv
// Decode stage immediate generator with a one-entry output register,
// HALT drain/halt FSM and a saturating downstream-stall counter.
module decode_imm_ctrl
  import decode_imm_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] instr_in,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        imm_valid,
  output logic [4:0]  opcode_out,
  output logic [15:0] imm_out,
  output logic        halt_out,
  output logic [7:0]  stall_cnt
);

  logic [1:0]  state_reg;
  logic [1:0]  state_next;
  logic [4:0]  opcode;
  imm_fmt_e    fmt;
  logic        imm_len;
  logic        imm_sign;
  logic [15:0] ext_imm;
  logic [15:0] imm_next;
  logic        load;

  assign opcode   = instr_in[15:11];
  assign fmt      = imm_fmt(opcode);
  assign imm_len  = (fmt == I5S) || (fmt == I5Z);
  assign imm_sign = (fmt == I5S) || (fmt == I8S);

  extender_block u_ext (
    .field    (instr_in[7:0]),
    .imm_len  (imm_len),
    .imm_sign (imm_sign),
    .imm      (ext_imm)
  );

  // Select the final immediate: J11 bypasses the extender, unknown opcodes give zero
  always_comb begin
    case (fmt)
      J11:     imm_next = {{5{instr_in[10]}}, instr_in[10:0]};
      NONE:    imm_next = 16'h0000;
      default: imm_next = ext_imm;
    endcase
  end

  // Reset is folded in so nothing is accepted while rst_n is low
  assign instr_ready = rst_n && (state_reg == ST_RUN) && !flush && (!imm_valid || ex_ready);
  assign load        = instr_valid && instr_ready;
  assign halt_out    = (state_reg == ST_HALTED);

  // Output register: flush squashes, otherwise load or drain on acceptance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imm_valid  <= 1'b0;
      opcode_out <= 5'h00;
      imm_out    <= 16'h0000;
    end else if (flush) begin
      imm_valid <= 1'b0;
    end else if (load) begin
      imm_valid  <= 1'b1;
      opcode_out <= opcode;
      imm_out    <= imm_next;
    end else if (imm_valid && ex_ready) begin
      imm_valid <= 1'b0;
    end
  end

  // HALT sequencing: drain the HALT entry into EX, then stop for good
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:    if (load && (opcode == OP_HALT)) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (flush)                      state_next = ST_RUN;
        else if (imm_valid && ex_ready) state_next = ST_HALTED;
      end
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= ST_RUN;
    else        state_reg <= state_next;
  end

  // Count cycles the held entry is blocked by EX, saturating at 255
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= 8'd0;
    end else if (imm_valid && !ex_ready && (stall_cnt != 8'hFF)) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_decode_imm_ctrl.sv
// Scoreboard bench for decode_imm_ctrl: directed cases then random traffic,
// checked against a behavioural model of the decode stage.
module tb_decode_imm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr_in = 16'h0000;
  logic        instr_valid = 1'b0;
  logic        flush = 1'b0;
  logic        ex_ready = 1'b0;
  logic        instr_ready;
  logic        imm_valid;
  logic [4:0]  opcode_out;
  logic [15:0] imm_out;
  logic        halt_out;
  logic [7:0]  stall_cnt;

  always #5 clk = ~clk;

  decode_imm_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .flush       (flush),
    .ex_ready    (ex_ready),
    .imm_valid   (imm_valid),
    .opcode_out  (opcode_out),
    .imm_out     (imm_out),
    .halt_out    (halt_out),
    .stall_cnt   (stall_cnt)
  );

  typedef struct {
    logic [4:0]  op;
    logic [15:0] imm;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  // Reference model state
  bit m_halted = 0, m_drain = 0, m_ready = 0, m_held = 0, m_after_rst = 0;
  int m_stall = 0;
  // What was applied during the previous cycle
  bit p_rst_n = 0, p_load = 0, p_flush = 0, p_ex_ready = 0, p_held = 0;
  logic [4:0] p_op = 5'h00;

  // Immediate value derived from the ISA rules with plain arithmetic
  function automatic logic [15:0] ref_imm(input logic [15:0] w);
    int op, bits, field, val;
    bit sgn;
    op = int'(w[15:11]);
    bits = 0;
    sgn = 0;
    if (op inside {8, 9, 16, 17, 19})              begin bits = 5;  sgn = 1; end
    else if (op inside {10, 11, 20, 21, 22, 23})   begin bits = 5;  sgn = 0; end
    else if (op inside {12, 13, 14, 15, 24, 5, 7}) begin bits = 8;  sgn = 1; end
    else if (op == 18)                             begin bits = 8;  sgn = 0; end
    else if (op inside {4, 6})                     begin bits = 11; sgn = 1; end
    if (bits == 0) return 16'h0000;
    field = int'(w) % (1 << bits);
    val = (sgn && field >= (1 << (bits - 1))) ? field - (1 << bits) : field;
    return 16'(val);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock of stimulus: advance the model over the edge, then drive new inputs
  task automatic cycle(input bit rn, input bit v, input logic [15:0] w,
                       input bit fl, input bit er);
    @(posedge clk);
    #1;
    if (!p_rst_n) begin
      m_halted = 0; m_drain = 0; m_stall = 0; m_after_rst = 1;
    end else begin
      m_after_rst = 0;
      if (p_held && !p_ex_ready && m_stall < 255) m_stall++;
      if (m_drain) begin
        if (p_flush) m_drain = 0;
        else if (p_held && p_ex_ready) begin m_drain = 0; m_halted = 1; end
      end else if (p_load && p_op == 5'd0) begin
        m_drain = 1;
      end
    end
    rst_n = rn; instr_valid = v; instr_in = w; flush = fl; ex_ready = er;
    m_held  = (sb.size() > 0);
    m_ready = rn && !m_halted && !m_drain && !fl && (!m_held || er);
    p_load  = v && m_ready;
    cyc++;
    if (p_load) sb.push_back('{op: w[15:11], imm: ref_imm(w), cyc: cyc});
    p_rst_n = rn; p_flush = fl; p_ex_ready = er; p_held = m_held; p_op = w[15:11];
    $display("cyc=%0d rst_n=%0d v=%0d instr=%h flush=%0d ex_ready=%0d load=%0d",
             cyc, rn, v, w, fl, er, p_load);
  endtask

  // Monitor: compare presented outputs against the scoreboard head
  always @(negedge clk) begin
    bit held;
    if (cyc > 0) begin
      held = (sb.size() > 0) && (sb[0].cyc < cyc);
      chk("instr_ready", 32'(instr_ready), 32'(m_ready));
      chk("imm_valid", 32'(imm_valid), 32'(held));
      if (held && imm_valid) begin
        chk("opcode_out", 32'(opcode_out), 32'(sb[0].op));
        chk("imm_out", 32'(imm_out), 32'(sb[0].imm));
      end
      chk("halt_out", 32'(halt_out), 32'(m_halted));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      if (m_after_rst) begin
        chk("rst_opcode", 32'(opcode_out), 32'h0);
        chk("rst_imm", 32'(imm_out), 32'h0);
      end
      if (held && (ex_ready || flush || !rst_n)) void'(sb.pop_front());
    end
  end

  // Load one instruction and check the produced immediate against a literal
  task automatic lit(input string name, input logic [15:0] w, input logic [15:0] exp_imm);
    cycle(1, 1, w, 0, 1);
    cycle(1, 0, 16'h0000, 0, 1);
    @(negedge clk);
    chk(name, 32'(imm_out), 32'(exp_imm));
  endtask

  initial begin
    bit rn, v, fl, er;
    logic [15:0] w;
    cycle(0, 0, 16'h0000, 0, 0);
    cycle(0, 0, 16'h0000, 0, 0);

    // Known immediates
    cycle(1, 0, 16'h0000, 0, 1);
    lit("addi_imm", 16'h423F, 16'hFFFF);
    chk("addi_op", 32'(opcode_out), 32'h08);
    lit("xori_imm", 16'h523F, 16'h001F);
    lit("lbi_imm",  16'hC180, 16'hFF80);
    lit("slbi_imm", 16'h9180, 16'h0080);
    lit("j_imm",    16'h27FF, 16'hFFFF);

    // Long downstream stall on a held LD
    cycle(1, 1, 16'h881F, 0, 0);
    for (int i = 0; i < 300; i++) cycle(1, $urandom % 2, 16'($urandom), 0, 0);
    @(negedge clk);
    chk("stall_sat", 32'(stall_cnt), 32'd255);
    cycle(1, 0, 16'h0000, 0, 1);
    cycle(1, 0, 16'h0000, 0, 1);

    // Flush with a valid incoming instruction and EX ready
    cycle(1, 1, 16'h4001, 0, 1);
    cycle(1, 1, 16'h4802, 1, 1);
    cycle(1, 0, 16'h0000, 0, 1);
    @(negedge clk);
    chk("flush_drop", 32'(imm_valid), 32'd0);

    // HALT drain then halted, then reset
    cycle(1, 1, 16'h0000, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 16'h0000, 0, 0);
    cycle(1, 0, 16'h0000, 0, 1);
    cycle(1, 1, 16'h4001, 0, 1);
    @(negedge clk);
    chk("halted", 32'(halt_out), 32'd1);
    cycle(0, 1, 16'h4001, 1, 1);
    cycle(1, 0, 16'h0000, 0, 0);
    @(negedge clk);
    chk("post_rst_halt", 32'(halt_out), 32'd0);
    chk("post_rst_stall", 32'(stall_cnt), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (m_halted) rn = ($urandom % 4 != 0);
      else          rn = ($urandom % 200 != 0);
      v  = ($urandom % 4 != 0);
      w  = 16'($urandom);
      fl = ($urandom % 16 == 0);
      er = ($urandom % 3 != 0);
      cycle(rn, v, w, fl, er);
    end
    cycle(1, 0, 16'h0000, 0, 1);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
